// File: rtl/riscv_m_pkg.sv
// Shared RV32M definitions: funct3 operation encodings and the
// multiply/divide unit state encoding.
package riscv_m_pkg;

    typedef enum logic [2:0] {
        F3_MUL    = 3'd0,
        F3_MULH   = 3'd1,
        F3_MULHSU = 3'd2,
        F3_MULHU  = 3'd3,
        F3_DIV    = 3'd4,
        F3_DIVU   = 3'd5,
        F3_REM    = 3'd6,
        F3_REMU   = 3'd7
    } m_funct3_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } md_state_e;

endpackage

// File: rtl/muldiv_unit_if.sv
// Issue/write-back bundle between the pipeline and the M-extension unit.
interface muldiv_unit_if #(parameter int unsigned XLEN = 32);

    logic            in_valid;
    logic            in_ready;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [4:0]      rd;
    logic            kill;
    logic            wb_we;
    logic [4:0]      wb_wa;
    logic [XLEN-1:0] wb_wd;

    modport master (
        output in_valid, funct3, op_a, op_b, rd, kill,
        input  in_ready, wb_we, wb_wa, wb_wd
    );

    modport slave (
        input  in_valid, funct3, op_a, op_b, rd, kill,
        output in_ready, wb_we, wb_wa, wb_wd
    );

endinterface

// File: rtl/muldiv_iter_core.sv
// Unsigned iterative datapath: shift-add multiply or restoring divide,
// one bit per step, over a 2*XLEN accumulator {hi, lo}.
module muldiv_iter_core #(
    parameter int unsigned XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic              div_mode,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic [2*XLEN-1:0] acc_nxt
);

    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   bq;
    logic              mode;
    logic [XLEN-1:0]   hi, lo;
    logic [XLEN:0]     sum, rsh, trial;

    // Multiply: lo holds the multiplier and shifts right under the growing product.
    // Divide: lo holds the dividend and shifts left as quotient bits enter.
    always_comb begin
        hi    = acc[2*XLEN-1:XLEN];
        lo    = acc[XLEN-1:0];
        sum   = {1'b0, hi} + (lo[0] ? {1'b0, bq} : '0);
        rsh   = {hi, lo[XLEN-1]};
        trial = rsh - {1'b0, bq};
        if (mode) begin
            if (!trial[XLEN])
                acc_nxt = {trial[XLEN-1:0], lo[XLEN-2:0], 1'b1};
            else
                acc_nxt = {rsh[XLEN-1:0], lo[XLEN-2:0], 1'b0};
        end else begin
            acc_nxt = {sum, lo[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            bq   <= '0;
            mode <= 1'b0;
        end else if (load) begin
            acc  <= {{XLEN{1'b0}}, a};
            bq   <= b;
            mode <= div_mode;
        end else if (step) begin
            acc  <= acc_nxt;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: FSM, sign handling, divide special cases,
// kill handling and the register-file write-back port.
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    muldiv_unit_if.slave  bus
);
    import riscv_m_pkg::*;

    localparam int unsigned     CW       = $clog2(XLEN);
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] SMIN     = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e         state, state_nxt;
    logic [CW-1:0]     cnt;
    m_funct3_e         f3, f3_q;
    logic [4:0]        rd_q, wa_q;
    logic [XLEN-1:0]   wd_q;
    logic              neg_q;

    logic              accept, fast, is_div, sgn_a, sgn_b, a_neg, b_neg, res_neg, last;
    logic [XLEN-1:0]   a_mag, b_mag, fast_res, calc_res, dres;
    logic [2*XLEN-1:0] prod, prod_s;

    always_comb begin
        f3      = m_funct3_e'(bus.funct3);
        is_div  = bus.funct3[2];
        sgn_a   = (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
        sgn_b   = (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
        a_neg   = sgn_a && bus.op_a[XLEN-1];
        b_neg   = sgn_b && bus.op_b[XLEN-1];
        a_mag   = a_neg ? -bus.op_a : bus.op_a;
        b_mag   = b_neg ? -bus.op_b : bus.op_b;
        res_neg = (f3 == F3_REM) ? a_neg : (a_neg ^ b_neg);
        fast    = is_div && ((bus.op_b == '0) ||
                  (sgn_b && (bus.op_a == SMIN) && (bus.op_b == '1)));
        if (bus.op_b == '0)
            fast_res = bus.funct3[1] ? bus.op_a : '1;
        else
            fast_res = bus.funct3[1] ? '0 : SMIN;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = (cnt == CNT_LAST);
        case (state)
            ST_IDLE: begin
                if (bus.in_valid && !bus.kill) begin
                    accept    = 1'b1;
                    state_nxt = fast ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (bus.kill)
                    state_nxt = ST_IDLE;
                else if (last)
                    state_nxt = ST_DONE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    muldiv_iter_core #(.XLEN(XLEN)) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept && !fast),
        .step     ((state == ST_CALC) && !bus.kill),
        .div_mode (is_div),
        .a        (a_mag),
        .b        (b_mag),
        .acc_nxt  (prod)
    );

    // Result is taken from the core's next-accumulator so wb_wd is registered
    // on the same edge as the final iteration.
    always_comb begin
        prod_s = neg_q ? -prod : prod;
        dres   = f3_q[1] ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
        case (f3_q)
            F3_MUL:                        calc_res = prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  calc_res = prod_s[2*XLEN-1:XLEN];
            default:                       calc_res = neg_q ? -dres : dres;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            f3_q  <= F3_MUL;
            rd_q  <= '0;
            neg_q <= 1'b0;
            wa_q  <= '0;
            wd_q  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt   <= '0;
                f3_q  <= f3;
                rd_q  <= bus.rd;
                neg_q <= res_neg;
                if (fast) begin
                    wa_q <= bus.rd;
                    wd_q <= fast_res;
                end
            end else if ((state == ST_CALC) && !bus.kill) begin
                cnt <= cnt + CW'(1);
                if (last) begin
                    wa_q <= rd_q;
                    wd_q <= calc_res;
                end
            end
        end
    end

    assign bus.in_ready = (state == ST_IDLE);
    assign bus.wb_we    = (state == ST_DONE) && !bus.kill && (wa_q != '0);
    assign bus.wb_wa    = wa_q;
    assign bus.wb_wd    = wd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, kill/reset
// sequences and random operations against an arithmetic reference model.
module tb_muldiv_unit;

    localparam logic [31:0] MIN = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_unit_if #(.XLEN(32)) bus ();
    muldiv_unit #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int nchk = 0;
    int nfail = 0;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        bit          fast;
    } vec_t;

    vec_t vt[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p, ua64, ub64;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        ub   = longint'({32'b0, b});
        ua64 = {32'b0, a};
        ub64 = {32'b0, b};
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua64 * ub64; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN && b == 32'hFFFF_FFFF) return MIN;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Entered and left at a negedge. lat = cycles after the accept edge with
    // in_ready low; k-th negedge sits between edges E(k-1) and E(k).
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] r, output logic [31:0] wd, output logic [4:0] wa,
                          output int lat, output int we_n, output int we_at);
        int guard;
        guard = 0;
        while (!bus.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        bus.in_valid = 1'b1;
        bus.funct3   = f;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.rd       = r;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat   = 0;
        we_n  = 0;
        we_at = -1;
        wd    = bus.wb_wd;
        wa    = bus.wb_wa;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (bus.wb_we) begin
                we_n++;
                we_at = k;
            end
            if (bus.in_ready) break;
            lat = k;
            wd  = bus.wb_wd;
            wa  = bus.wb_wa;
        end
    endtask

    task automatic apply(input string nm, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] r, input logic [31:0] exp,
                         input bit fast);
        logic [31:0] wd;
        logic [4:0]  wa;
        int lat, we_n, we_at;
        run_op(f, a, b, r, wd, wa, lat, we_n, we_at);
        chk({nm, "_wd"}, wd, exp);
        chk({nm, "_wa"}, 32'(wa), 32'(r));
        chk({nm, "_next_accept_edge"}, 32'(lat + 1), fast ? 32'd2 : 32'd34);
        chk({nm, "_we_count"}, 32'(we_n), (r != 0) ? 32'd1 : 32'd0);
        if (r != 0) chk({nm, "_commit_edge"}, 32'(we_at), 32'(lat));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int we_seen;
        bus.in_valid = 1'b0;
        bus.funct3   = '0;
        bus.op_a     = '0;
        bus.op_b     = '0;
        bus.rd       = '0;
        bus.kill     = 1'b0;

        vt[0]  = '{3'd0, 32'd7,          32'd6,          5'd5,  32'd42,         1'b0};
        vt[1]  = '{3'd1, MIN,            MIN,            5'd1,  32'h4000_0000,  1'b0};
        vt[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd2,  32'hFFFF_FFFE,  1'b0};
        vt[3]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,          5'd3,  32'hFFFF_FFFF,  1'b0};
        vt[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,          5'd4,  32'hFFFF_FFFD,  1'b0};
        vt[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,          5'd6,  32'hFFFF_FFFF,  1'b0};
        vt[6]  = '{3'd5, 32'd100,        32'd7,          5'd7,  32'd14,         1'b0};
        vt[7]  = '{3'd7, 32'd100,        32'd7,          5'd8,  32'd2,          1'b0};
        vt[8]  = '{3'd5, 32'd5,          32'd0,          5'd9,  32'hFFFF_FFFF,  1'b1};
        vt[9]  = '{3'd6, 32'd5,          32'd0,          5'd10, 32'd5,          1'b1};
        vt[10] = '{3'd4, MIN,            32'hFFFF_FFFF,  5'd11, MIN,            1'b1};
        vt[11] = '{3'd6, MIN,            32'hFFFF_FFFF,  5'd12, 32'd0,          1'b1};
        vt[12] = '{3'd0, 32'd123,        32'd456,        5'd0,  32'd56088,      1'b0};
        vt[13] = '{3'd4, 32'd7,          32'hFFFF_FFFE,  5'd31, 32'hFFFF_FFFD,  1'b0};

        @(negedge clk);
        @(negedge clk);
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset_wb_we",    32'(bus.wb_we),    32'd0);
        chk("reset_wb_wa",    32'(bus.wb_wa),    32'd0);
        chk("reset_wb_wd",    bus.wb_wd,         32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++)
            apply($sformatf("vec%0d", i), vt[i].f, vt[i].a, vt[i].b, vt[i].rd, vt[i].exp, vt[i].fast);

        // kill asserted with in_valid in IDLE: nothing accepted
        bus.in_valid = 1'b1; bus.kill = 1'b1;
        bus.funct3 = 3'd0; bus.op_a = 32'd5; bus.op_b = 32'd5; bus.rd = 5'd13;
        @(negedge clk);
        bus.in_valid = 1'b0; bus.kill = 1'b0;
        chk("idle_kill_in_ready", 32'(bus.in_ready), 32'd1);
        we_seen = 0;
        repeat (3) begin @(negedge clk); if (bus.wb_we) we_seen++; end
        chk("idle_kill_no_we", 32'(we_seen), 32'd0);

        // kill 10 edges into CALC
        bus.in_valid = 1'b1;
        bus.funct3 = 3'd0; bus.op_a = 32'd9; bus.op_b = 32'd9; bus.rd = 5'd14;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 bus.kill = 1'b1;
        @(posedge clk);
        #1 bus.kill = 1'b0;
        @(negedge clk);
        chk("kill_in_ready", 32'(bus.in_ready), 32'd1);
        we_seen = 0;
        repeat (40) begin @(negedge clk); if (bus.wb_we) we_seen++; end
        chk("kill_no_we", 32'(we_seen), 32'd0);
        apply("after_kill_mul", 3'd0, 32'd3, 32'd3, 5'd15, 32'd9, 1'b0);

        // reset mid-CALC
        bus.in_valid = 1'b1;
        bus.funct3 = 3'd0; bus.op_a = 32'd11; bus.op_b = 32'd11; bus.rd = 5'd4;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_wb_we", 32'(bus.wb_we), 32'd0);
        chk("rst_mid_wb_wa", 32'(bus.wb_wa), 32'd0);
        chk("rst_mid_wb_wd", bus.wb_wd,      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_release_in_ready", 32'(bus.in_ready), 32'd1);
        we_seen = 0;
        repeat (40) begin @(negedge clk); if (bus.wb_we) we_seen++; end
        chk("rst_abandon_no_we", 32'(we_seen), 32'd0);

        // random operations against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  f;
            logic [31:0] a, b;
            logic [4:0]  r;
            bit          fst;
            f = 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 7) == 0) ? MIN : $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            r = 5'($urandom_range(0, 31));
            fst = f[2] && ((b == 0) || (!f[0] && a == MIN && b == 32'hFFFF_FFFF));
            apply($sformatf("rnd%0d_f%0d", i, f), f, a, b, r, ref_op(f, a, b), fst);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
